// File: rtl/maze_pkg.sv
// Shared maze definitions: move encoding, grid size, frame state encoding.
package maze_pkg;

   localparam int GRID = 17;

   localparam logic [1:0] DIR_RIGHT = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_UP    = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/maze_rle_fifo.sv
// Token FIFO: register array, wrapping pointers, occupancy counter.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module maze_rle_fifo #(
   parameter int WIDTH = 7,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == CNT_FULL);
   assign empty = (count == '0);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign rdata = mem[rd_ptr];

   // Storage, pointers and occupancy update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/maze_path_rle.sv
// Maze move stream post-processor: run-length encodes moves into a token FIFO,
// tracks walker position from (1,1), and summarises each frame.
//
// state | meaning
// IDLE  | no frame in progress
// RUN   | frame in progress, one move per cycle
// DONE  | frame just closed; frame_done pulses, summary registers valid
module maze_path_rle #(
   parameter int GRID       = maze_pkg::GRID,
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_W      = 5,
   parameter int STEP_W     = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [1:0]        in_dir,
   output logic              rle_valid,
   input  logic              rle_ready,
   output logic [1:0]        rle_dir,
   output logic [LEN_W-1:0]  rle_len,
   output logic              frame_done,
   output logic [STEP_W-1:0] frame_steps,
   output logic              frame_ok,
   output logic              bad_move,
   output logic              overflow
);
   import maze_pkg::*;

   localparam int POS_W = $clog2(GRID + 2);
   localparam int TOK_W = 2 + LEN_W;
   localparam logic [POS_W-1:0]  POS_ONE  = POS_W'(1);
   localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(GRID);
   localparam logic [LEN_W-1:0]  RUN_MAX  = '1;
   localparam logic [STEP_W-1:0] STEP_SAT = '1;

   state_t            state, state_nxt;
   logic [1:0]        cur_dir;
   logic [LEN_W-1:0]  run_len;
   logic [POS_W-1:0]  row, col;
   logic [POS_W-1:0]  base_row, base_col, next_row, next_col;
   logic [STEP_W-1:0] steps;
   logic              frame_start, mid_move, frame_end;
   logic              move_bad, push, pop, full, empty, drop;
   logic [TOK_W-1:0]  head_tok;

   // Frame state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and per-cycle frame events.
   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      mid_move    = 1'b0;
      frame_end   = 1'b0;
      case (state)
         IDLE: if (in_valid) begin
            state_nxt   = RUN;
            frame_start = 1'b1;
         end
         RUN: if (in_valid) begin
            mid_move  = 1'b1;
         end else begin
            state_nxt = DONE;
            frame_end = 1'b1;
         end
         DONE: begin
            state_nxt   = in_valid ? RUN : IDLE;
            frame_start = in_valid;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign frame_done = (state == DONE);

   // Candidate position for this move; a new frame starts from (1,1).
   always_comb begin
      base_row = frame_start ? POS_ONE : row;
      base_col = frame_start ? POS_ONE : col;
      next_row = base_row;
      next_col = base_col;
      move_bad = 1'b0;
      case (in_dir)
         DIR_RIGHT: if (base_col == POS_MAX) move_bad = 1'b1; else next_col = base_col + POS_ONE;
         DIR_DOWN:  if (base_row == POS_MAX) move_bad = 1'b1; else next_row = base_row + POS_ONE;
         DIR_LEFT:  if (base_col == POS_ONE) move_bad = 1'b1; else next_col = base_col - POS_ONE;
         default:   if (base_row == POS_ONE) move_bad = 1'b1; else next_row = base_row - POS_ONE;
      endcase
   end

   // A run closes on a direction change, on reaching the maximum length, or at frame end.
   assign push = frame_end || (mid_move && ((in_dir != cur_dir) || (run_len == RUN_MAX)));
   assign pop  = rle_valid && rle_ready;
   assign drop = push && full && !pop;

   // Run encoder, position tracker, step counter and frame summary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_dir     <= DIR_RIGHT;
         run_len     <= '0;
         row         <= POS_ONE;
         col         <= POS_ONE;
         steps       <= '0;
         frame_steps <= '0;
         frame_ok    <= 1'b0;
         bad_move    <= 1'b0;
         overflow    <= 1'b0;
      end else if (frame_start) begin
         cur_dir  <= in_dir;
         run_len  <= LEN_W'(1);
         steps    <= STEP_W'(1);
         row      <= next_row;
         col      <= next_col;
         bad_move <= move_bad;
         overflow <= 1'b0;
      end else if (mid_move) begin
         if (push) begin
            cur_dir <= in_dir;
            run_len <= LEN_W'(1);
         end else begin
            run_len <= run_len + LEN_W'(1);
         end
         if (steps != STEP_SAT) steps <= steps + STEP_W'(1);
         row      <= next_row;
         col      <= next_col;
         bad_move <= bad_move | move_bad;
         if (drop) overflow <= 1'b1;
      end else if (frame_end) begin
         frame_steps <= steps;
         frame_ok    <= (row == POS_MAX) && (col == POS_MAX) && !bad_move;
         if (drop) overflow <= 1'b1;
      end
   end

   maze_rle_fifo #(
      .WIDTH (TOK_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({cur_dir, run_len}),
      .pop   (pop),
      .rdata (head_tok),
      .full  (full),
      .empty (empty)
   );

   assign rle_valid = !empty;
   assign rle_dir   = head_tok[TOK_W-1 -: 2];
   assign rle_len   = head_tok[LEN_W-1:0];

endmodule

// File: tb/tb_maze_path_rle.sv
// Bench for maze_path_rle: a reference model of run encoding, position and frame
// summary fills expected-token and expected-summary queues while moves are driven;
// negedge monitors pop and compare when the DUT presents tokens or frame_done.
module tb_maze_path_rle;

   localparam int GRID = 17;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Default instance (LEN_W=5)
   logic       in_valid, rle_ready, rle_valid, frame_done, frame_ok, bad_move, overflow;
   logic [1:0] in_dir, rle_dir;
   logic [4:0] rle_len;
   logic [9:0] frame_steps;

   // Short-run instance (LEN_W=3)
   logic       in_valid3, rle_ready3, rle_valid3, frame_done3, frame_ok3, bad_move3, overflow3;
   logic [1:0] in_dir3, rle_dir3;
   logic [2:0] rle_len3;
   logic [9:0] frame_steps3;

   maze_path_rle #(.GRID(17), .FIFO_DEPTH(8), .LEN_W(5), .STEP_W(10)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_dir(in_dir),
      .rle_valid(rle_valid), .rle_ready(rle_ready), .rle_dir(rle_dir), .rle_len(rle_len),
      .frame_done(frame_done), .frame_steps(frame_steps), .frame_ok(frame_ok),
      .bad_move(bad_move), .overflow(overflow));

   maze_path_rle #(.GRID(17), .FIFO_DEPTH(8), .LEN_W(3), .STEP_W(10)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_dir(in_dir3),
      .rle_valid(rle_valid3), .rle_ready(rle_ready3), .rle_dir(rle_dir3), .rle_len(rle_len3),
      .frame_done(frame_done3), .frame_steps(frame_steps3), .frame_ok(frame_ok3),
      .bad_move(bad_move3), .overflow(overflow3));

   int n_checks = 0;
   int n_pass   = 0;

   int exp_q[$];
   int exp_sum[$];
   int exp_q3[$];
   int exp_sum3[$];
   logic [1:0] stim_q[$];

   int m_cur, m_len, m_row, m_col, m_steps;
   bit m_bad, m_ovf;

   int tok_e, tok_o, tok_e3, tok_o3, sum_e, sum_e3;

   // Token scoreboard, default instance
   always @(negedge clk) begin
      if (rst_n && rle_valid && rle_ready) begin
         n_checks++;
         tok_o = int'(rle_dir) * 256 + int'(rle_len);
         if (exp_q.size() == 0) begin
            $display("FAIL token: unexpected dir=%0d len=%0d", rle_dir, rle_len);
         end else begin
            tok_e = exp_q.pop_front();
            if (tok_o !== tok_e)
               $display("FAIL token: got dir=%0d len=%0d want dir=%0d len=%0d",
                        tok_o / 256, tok_o % 256, tok_e / 256, tok_e % 256);
            else n_pass++;
         end
      end
   end

   // Token scoreboard, short-run instance
   always @(negedge clk) begin
      if (rst_n && rle_valid3 && rle_ready3) begin
         n_checks++;
         tok_o3 = int'(rle_dir3) * 256 + int'(rle_len3);
         if (exp_q3.size() == 0) begin
            $display("FAIL token3: unexpected dir=%0d len=%0d", rle_dir3, rle_len3);
         end else begin
            tok_e3 = exp_q3.pop_front();
            if (tok_o3 !== tok_e3)
               $display("FAIL token3: got dir=%0d len=%0d want dir=%0d len=%0d",
                        tok_o3 / 256, tok_o3 % 256, tok_e3 / 256, tok_e3 % 256);
            else n_pass++;
         end
      end
   end

   // Frame summary scoreboard, default instance
   always @(negedge clk) begin
      if (rst_n && frame_done) begin
         if (exp_sum.size() == 0) begin
            n_checks++;
            $display("FAIL summary: unexpected frame_done steps=%0d", frame_steps);
         end else begin
            sum_e = exp_sum.pop_front();
            n_checks += 4;
            if (int'(frame_steps) !== (sum_e >> 3))
               $display("FAIL frame_steps: got %0d want %0d", frame_steps, sum_e >> 3);
            else n_pass++;
            if (frame_ok !== 1'((sum_e >> 2) & 1))
               $display("FAIL frame_ok: got %0d want %0d", frame_ok, (sum_e >> 2) & 1);
            else n_pass++;
            if (bad_move !== 1'((sum_e >> 1) & 1))
               $display("FAIL bad_move: got %0d want %0d", bad_move, (sum_e >> 1) & 1);
            else n_pass++;
            if (overflow !== 1'(sum_e & 1))
               $display("FAIL overflow: got %0d want %0d", overflow, sum_e & 1);
            else n_pass++;
         end
      end
   end

   // Frame summary scoreboard, short-run instance
   always @(negedge clk) begin
      if (rst_n && frame_done3) begin
         if (exp_sum3.size() == 0) begin
            n_checks++;
            $display("FAIL summary3: unexpected frame_done steps=%0d", frame_steps3);
         end else begin
            sum_e3 = exp_sum3.pop_front();
            n_checks += 2;
            if (int'(frame_steps3) !== (sum_e3 >> 3))
               $display("FAIL frame_steps3: got %0d want %0d", frame_steps3, sum_e3 >> 3);
            else n_pass++;
            if (frame_ok3 !== 1'((sum_e3 >> 2) & 1))
               $display("FAIL frame_ok3: got %0d want %0d", frame_ok3, (sum_e3 >> 2) & 1);
            else n_pass++;
         end
      end
   end

   task automatic fill(input int n, input logic [1:0] d);
      for (int i = 0; i < n; i++) stim_q.push_back(d);
   endtask

   task automatic fill_alt(input int n);
      for (int i = 0; i < n; i++) stim_q.push_back((i % 2 == 0) ? 2'd0 : 2'd1);
   endtask

   task automatic mpush(input bit d3, input int dir, input int len);
      if (d3) exp_q3.push_back(dir * 256 + len);
      else if (!rle_ready && exp_q.size() >= 8) m_ovf = 1'b1;
      else exp_q.push_back(dir * 256 + len);
   endtask

   // Drive stim_q as one frame on the chosen instance and record expected results.
   task automatic drive_frame(input bit d3, input int gap);
      int max_run;
      int s;
      logic [1:0] d;
      max_run = d3 ? 7 : 31;
      m_row = 1; m_col = 1; m_bad = 1'b0; m_ovf = 1'b0; m_steps = 0; m_len = 0; m_cur = 0;
      foreach (stim_q[i]) begin
         d = stim_q[i];
         @(posedge clk); #1;
         if (d3) begin in_valid3 = 1'b1; in_dir3 = d; end
         else    begin in_valid  = 1'b1; in_dir  = d; end
         if (i == 0) begin
            m_cur = int'(d); m_len = 1;
         end else if (int'(d) == m_cur && m_len < max_run) begin
            m_len++;
         end else begin
            mpush(d3, m_cur, m_len);
            m_cur = int'(d); m_len = 1;
         end
         if (m_steps < 1023) m_steps++;
         case (d)
            2'd0: if (m_col == GRID) m_bad = 1'b1; else m_col++;
            2'd1: if (m_row == GRID) m_bad = 1'b1; else m_row++;
            2'd2: if (m_col == 1)    m_bad = 1'b1; else m_col--;
            default: if (m_row == 1) m_bad = 1'b1; else m_row--;
         endcase
      end
      @(posedge clk); #1;
      if (d3) in_valid3 = 1'b0; else in_valid = 1'b0;
      mpush(d3, m_cur, m_len);
      s = m_steps * 8 + ((m_row == GRID && m_col == GRID && !m_bad) ? 4 : 0)
          + (m_bad ? 2 : 0) + (m_ovf ? 1 : 0);
      if (d3) exp_sum3.push_back(s); else exp_sum.push_back(s);
      stim_q.delete();
      repeat (gap) @(posedge clk);
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || exp_sum.size() != 0 || exp_q3.size() != 0 ||
              exp_sum3.size() != 0) && k < 300) begin
         @(posedge clk);
         k++;
      end
      @(negedge clk);
      n_checks++;
      if (k >= 300)
         $display("FAIL %s drain: pending tok=%0d sum=%0d tok3=%0d sum3=%0d want all 0",
                  name, exp_q.size(), exp_sum.size(), exp_q3.size(), exp_sum3.size());
      else n_pass++;
   endtask

   task automatic test_reset();
      #12;
      n_checks += 2;
      if (rle_valid !== 1'b0) $display("FAIL reset rle_valid: got %0d want 0", rle_valid);
      else n_pass++;
      if ({rle_dir, rle_len, frame_done, frame_steps, frame_ok, bad_move, overflow} !== '0)
         $display("FAIL reset outputs: got %b want 0",
                  {rle_dir, rle_len, frame_done, frame_steps, frame_ok, bad_move, overflow});
      else n_pass++;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_straight();
      fill(16, 2'd0);
      fill(16, 2'd1);
      drive_frame(1'b0, 2);
      wait_drain("straight");
   endtask

   task automatic test_alternating();
      fill_alt(32);
      drive_frame(1'b0, 2);
      wait_drain("alternating");
   endtask

   task automatic test_overflow();
      rle_ready = 1'b0;
      fill_alt(10);
      drive_frame(1'b0, 2);
      @(negedge clk);
      n_checks += 2;
      if (rle_valid !== 1'b1) $display("FAIL ovf rle_valid: got %0d want 1", rle_valid);
      else n_pass++;
      if (overflow !== 1'b1) $display("FAIL ovf sticky: got %0d want 1", overflow);
      else n_pass++;
      @(posedge clk); #1;
      rle_ready = 1'b1;
      wait_drain("overflow");
   endtask

   task automatic test_len_w3();
      fill(16, 2'd0);
      drive_frame(1'b1, 2);
      wait_drain("len_w3");
      n_checks++;
      if (u_dut3.col !== 5'd17 || u_dut3.row !== 5'd1)
         $display("FAIL len_w3 pos: got row=%0d col=%0d want row=1 col=17", u_dut3.row, u_dut3.col);
      else n_pass++;
   endtask

   task automatic test_bad_move();
      fill(1, 2'd3);
      drive_frame(1'b0, 2);
      wait_drain("bad_move");
      n_checks += 2;
      if (u_dut.row !== 5'd1 || u_dut.col !== 5'd1)
         $display("FAIL bad pos: got row=%0d col=%0d want row=1 col=1", u_dut.row, u_dut.col);
      else n_pass++;
      if (bad_move !== 1'b1) $display("FAIL bad sticky: got %0d want 1", bad_move);
      else n_pass++;
      fill(1, 2'd0);
      drive_frame(1'b0, 2);
      wait_drain("bad_clear");
      n_checks++;
      if (bad_move !== 1'b0) $display("FAIL bad clear: got %0d want 0", bad_move);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      fill(3, 2'd0);
      drive_frame(1'b0, 0);
      fill(16, 2'd0);
      fill(16, 2'd1);
      drive_frame(1'b0, 2);
      wait_drain("back_to_back");
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_dir   = (i < 2) ? 2'd0 : 2'd1;
         if (i == 2) exp_q.push_back(0 * 256 + 2);
      end
      @(posedge clk); #1;
      rle_ready = 1'b0;
      @(posedge clk); #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      #1;
      n_checks += 2;
      if (rle_valid !== 1'b0) $display("FAIL mid_reset rle_valid: got %0d want 0", rle_valid);
      else n_pass++;
      if ({rle_dir, rle_len, frame_done, frame_steps, frame_ok, bad_move, overflow} !== '0)
         $display("FAIL mid_reset outputs: got %b want 0",
                  {rle_dir, rle_len, frame_done, frame_steps, frame_ok, bad_move, overflow});
      else n_pass++;
      @(posedge clk); #1;
      rst_n     = 1'b1;
      rle_ready = 1'b1;
      fill(16, 2'd0);
      fill(16, 2'd1);
      drive_frame(1'b0, 2);
      wait_drain("mid_reset");
   endtask

   initial begin
      in_valid   = 1'b0;
      in_dir     = 2'd0;
      rle_ready  = 1'b1;
      in_valid3  = 1'b0;
      in_dir3    = 2'd0;
      rle_ready3 = 1'b1;
      test_reset();
      test_straight();
      test_alternating();
      test_overflow();
      test_len_w3();
      test_bad_move();
      test_back_to_back();
      test_mid_reset();
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
